// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-controller types: sequencer states, default register width
// and the bundled stage control outputs.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic fetch_hold;
    logic decode_hold;
    logic buffer_hold;
    logic buffer_bubble;
    logic fetch_flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/decode_hazard_ctrl_hazard_cmp.sv
// Combinational load-use comparator between the decode instruction and a
// load sitting in the decode buffer.
module hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              d_valid,
  input  logic              d_use_a,
  input  logic              d_use_b,
  input  logic [REG_AW-1:0] d_rs_a,
  input  logic [REG_AW-1:0] d_rs_b,
  input  logic              x_valid,
  input  logic              x_regwrite,
  input  logic              x_memtoreg,
  input  logic [REG_AW-1:0] x_write_addr,
  output logic              hazard
);

  logic x_is_load;
  logic match_a;
  logic match_b;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign x_is_load = x_valid & x_regwrite & x_memtoreg & (x_write_addr != '0);
  assign match_a   = d_use_a & (d_rs_a == x_write_addr);
  assign match_b   = d_use_b & (d_rs_b == x_write_addr);
  assign hazard    = x_is_load & d_valid & (match_a | match_b);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode->execute buffer sequencer: load-use stalls, branch flushes and
// memory back-pressure holds. Optional counters under DECODE_HAZARD_CTRL_PERF_EN.
module decode_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW         = REG_AW_DEFAULT,
  parameter int BRANCH_PENALTY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic              d_use_a,
  input  logic              d_use_b,
  input  logic [REG_AW-1:0] d_rs_a,
  input  logic [REG_AW-1:0] d_rs_b,
  input  logic              x_valid,
  input  logic              x_regwrite,
  input  logic              x_memtoreg,
  input  logic [REG_AW-1:0] x_write_addr,
  input  logic              x_branch_taken,
  input  logic              m_busy,
  output logic              fetch_hold,
  output logic              decode_hold,
  output logic              buffer_hold,
  output logic              buffer_bubble,
  output logic              fetch_flush
`ifdef DECODE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_branch_flushes,
  output logic [31:0]       perf_load_use
`endif
);

  localparam logic [3:0] PENALTY_M1 = 4'(BRANCH_PENALTY - 1);

  pipe_state_e state_q, state_d;
  pipe_state_e saved_q, saved_d;
  pipe_state_e eff_state;
  logic [3:0]  bcnt_q, bcnt_d;
  logic        hazard;
  logic        branch;
  logic        load_use;
  pipe_ctrl_t  ctrl;

  hazard_cmp #(.REG_AW(REG_AW)) u_hazard_cmp (
    .d_valid      (d_valid),
    .d_use_a      (d_use_a),
    .d_use_b      (d_use_b),
    .d_rs_a       (d_rs_a),
    .d_rs_b       (d_rs_b),
    .x_valid      (x_valid),
    .x_regwrite   (x_regwrite),
    .x_memtoreg   (x_memtoreg),
    .x_write_addr (x_write_addr),
    .hazard       (hazard)
  );

  // MEM_WAIT is transparent once m_busy drops: act as the state it interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;
  assign branch    = x_valid & x_branch_taken;
  assign load_use  = ~m_busy & ~branch & (eff_state == RUN) & hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      saved_q <= RUN;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    bcnt_d  = bcnt_q;
    if (m_busy) begin
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) saved_d = state_q;
    end else if (branch) begin
      saved_d = RUN;
      if (BRANCH_PENALTY > 1) begin
        state_d = FLUSH;
        bcnt_d  = PENALTY_M1;
      end else begin
        state_d = RUN;
        bcnt_d  = '0;
      end
    end else if (eff_state == FLUSH) begin
      saved_d = RUN;
      if (bcnt_q > 4'd1) begin
        state_d = FLUSH;
        bcnt_d  = bcnt_q - 4'd1;
      end else begin
        state_d = RUN;
        bcnt_d  = '0;
      end
    end else begin
      state_d = RUN;
      saved_d = RUN;
    end
  end

  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl.fetch_flush   = 1'b1;
      ctrl.buffer_bubble = 1'b1;
    end else if (m_busy) begin
      ctrl.fetch_hold  = 1'b1;
      ctrl.decode_hold = 1'b1;
      ctrl.buffer_hold = 1'b1;
    end else if (branch) begin
      ctrl.fetch_flush   = 1'b1;
      ctrl.buffer_bubble = 1'b1;
    end else if (eff_state == FLUSH) begin
      ctrl.buffer_bubble = 1'b1;
    end else if (load_use) begin
      ctrl.fetch_hold    = 1'b1;
      ctrl.decode_hold   = 1'b1;
      ctrl.buffer_bubble = 1'b1;
    end
  end

  assign fetch_hold    = ctrl.fetch_hold;
  assign decode_hold   = ctrl.decode_hold;
  assign buffer_hold   = ctrl.buffer_hold;
  assign buffer_bubble = ctrl.buffer_bubble;
  assign fetch_flush   = ctrl.fetch_flush;

`ifdef DECODE_HAZARD_CTRL_PERF_EN
  logic any_stall;
  assign any_stall = ctrl.fetch_hold | ctrl.decode_hold | ctrl.buffer_hold | ctrl.buffer_bubble;

  // Counters saturate rather than wrap so long runs never under-report.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles   <= '0;
      perf_branch_flushes <= '0;
      perf_load_use       <= '0;
    end else begin
      if (any_stall && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (branch && !m_busy && perf_branch_flushes != '1)
        perf_branch_flushes <= perf_branch_flushes + 32'd1;
      if (load_use && perf_load_use != '1)
        perf_load_use <= perf_load_use + 32'd1;
    end
  end
`endif

endmodule
